// File: rtl/audio_adc_rx.sv
// WM8731 ADC capture: I2S pins -> signed stereo sample pairs over valid/ready.
// Optional peak meters are built only when AUDIO_ADC_RX_PEAK_EN is defined.
module audio_adc_rx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_BITS    = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    aud_bclk,
  input  logic                    aud_adclrck,
  input  logic                    aud_adcdat,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  input  logic                    overrun_clr,
  output logic [SAMPLE_WIDTH-1:0] peak_left,
  output logic [SAMPLE_WIDTH-1:0] peak_right,
  input  logic                    peak_clr
);
  localparam int CW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_WIDTH - 1);
  localparam logic [SAMPLE_WIDTH-1:0] MSB_BIT = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0]  bclk_sync_r, lrck_sync_r, dat_sync_r;
  logic                    bclk_d_r, rise_r, lrck_r, lrck_prev_r, dat_r;
  logic                    lrck_edge_s;
  state_t                  state_r, state_nx_s;
  logic                    chan_r, chan_nx_s;
  logic [CW-1:0]           cnt_r, cnt_nx_s;
  logic [SAMPLE_WIDTH-1:0] shift_r, shift_nx_s, bit_or_s, word_s, stage_left_r;
  logic                    store_s, have_left_r, pair_done_s;

  // Pin synchronizers; the BCLK rise is registered so data and LRCK stay aligned with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync_r <= '0;
      lrck_sync_r <= '0;
      dat_sync_r  <= '0;
      bclk_d_r    <= 1'b0;
      rise_r      <= 1'b0;
      lrck_r      <= 1'b0;
      lrck_prev_r <= 1'b0;
      dat_r       <= 1'b0;
    end else begin
      bclk_sync_r <= {bclk_sync_r[SYNC_STAGES-2:0], aud_bclk};
      lrck_sync_r <= {lrck_sync_r[SYNC_STAGES-2:0], aud_adclrck};
      dat_sync_r  <= {dat_sync_r[SYNC_STAGES-2:0], aud_adcdat};
      bclk_d_r    <= bclk_sync_r[SYNC_STAGES-1];
      rise_r      <= bclk_sync_r[SYNC_STAGES-1] & ~bclk_d_r;
      lrck_r      <= lrck_sync_r[SYNC_STAGES-1];
      dat_r       <= dat_sync_r[SYNC_STAGES-1];
      if (rise_r) lrck_prev_r <= lrck_r;
    end
  end

  assign lrck_edge_s = rise_r && (lrck_r != lrck_prev_r);

  // Deserializer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_ALIGN;
      chan_r  <= 1'b0;
      cnt_r   <= '0;
      shift_r <= '0;
    end else begin
      state_r <= state_nx_s;
      chan_r  <= chan_nx_s;
      cnt_r   <= cnt_nx_s;
      shift_r <= shift_nx_s;
    end
  end

  // Next-state logic; the rise that reveals an LRCK edge carries the I2S delay bit and is dropped
  always_comb begin
    state_nx_s = state_r;
    chan_nx_s  = chan_r;
    cnt_nx_s   = cnt_r;
    shift_nx_s = shift_r;
    store_s    = 1'b0;
    bit_or_s   = dat_r ? (MSB_BIT >> cnt_r) : '0;
    word_s     = shift_r;
    case (state_r)
      ST_ALIGN: begin
        if (lrck_edge_s && !lrck_r) begin
          state_nx_s = ST_SKIP;
          chan_nx_s  = 1'b0;
        end else begin
          state_nx_s = ST_ALIGN;
        end
      end
      ST_SKIP: begin
        state_nx_s = ST_SHIFT;
        cnt_nx_s   = '0;
        shift_nx_s = '0;
      end
      ST_SHIFT: begin
        if (lrck_edge_s) begin
          // short slot: the word is already left-aligned with zero LSBs
          store_s    = 1'b1;
          word_s     = shift_r;
          chan_nx_s  = lrck_r;
          state_nx_s = ST_SKIP;
        end else if (rise_r) begin
          shift_nx_s = shift_r | bit_or_s;
          cnt_nx_s   = cnt_r + 1'b1;
          if (cnt_r == CNT_LAST) begin
            store_s    = 1'b1;
            word_s     = shift_r | bit_or_s;
            state_nx_s = ST_DRAIN;
          end else begin
            state_nx_s = ST_SHIFT;
          end
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DRAIN: begin
        if (lrck_edge_s) begin
          chan_nx_s  = lrck_r;
          state_nx_s = ST_SKIP;
        end else if (rise_r) begin
          cnt_nx_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 1'b1;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        state_nx_s = ST_ALIGN;
      end
    endcase
  end

  assign pair_done_s = store_s && chan_r && have_left_r;

  // Left staging; a right word only completes a pair if a left word precedes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_left_r <= '0;
      have_left_r  <= 1'b0;
    end else if (store_s) begin
      if (!chan_r) begin
        stage_left_r <= word_s;
        have_left_r  <= 1'b1;
      end else begin
        have_left_r  <= 1'b0;
      end
    end
  end

  // Output handshake and sticky overrun (set beats clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_sample  <= '0;
      right_sample <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (pair_done_s && (!out_valid || out_ready)) begin
        left_sample  <= stage_left_r;
        right_sample <= word_s;
        out_valid    <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (pair_done_s && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef AUDIO_ADC_RX_PEAK_EN
  function automatic logic [SAMPLE_WIDTH-1:0] magnitude(input logic [SAMPLE_WIDTH-1:0] x);
    magnitude = x[SAMPLE_WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  // Peak hold per channel; a clear discards any same-cycle update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_left  <= '0;
      peak_right <= '0;
    end else if (peak_clr) begin
      peak_left  <= '0;
      peak_right <= '0;
    end else if (store_s) begin
      if (!chan_r && (magnitude(word_s) > peak_left)) peak_left <= magnitude(word_s);
      if (chan_r && (magnitude(word_s) > peak_right)) peak_right <= magnitude(word_s);
    end
  end
`else
  logic unused_peak_clr_s;
  assign unused_peak_clr_s = peak_clr;
  assign peak_left  = '0;
  assign peak_right = '0;
`endif
endmodule
